// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Purpose:
//   Frames the byte stream coming out of the UART receiver into 5-byte
//   commands: SYNC_BYTE, CMD, DATA_HI, DATA_LO, CHK where
//   CHK = CMD ^ DATA_HI ^ DATA_LO. A frame is abandoned if the line goes quiet
//   for more than TO_CYCLES clocks between two of its bytes. The most recent
//   valid frame is held on cmd/data with a level cmd_rdy until the consumer
//   acknowledges it.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   rx_data[7:0] in   received byte, valid while rdy=1
//   rdy          in   receiver byte-ready level
//   clr_rdy      out  combinational acknowledge to the receiver (= rdy & rst_n)
//   clr_cmd_rdy  in   consumer acknowledge, clears cmd_rdy at the next edge
//   cmd[7:0]     out  command byte of the last valid frame
//   data[15:0]   out  {DATA_HI, DATA_LO} of the last valid frame
//   cmd_rdy      out  level, a new valid frame is waiting
//   chk_err      out  one-cycle pulse on checksum mismatch
//   to_err       out  one-cycle pulse on inter-byte timeout
//   cmd_ovr      out  one-cycle pulse when a valid frame replaces an
//                     unacknowledged one
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TO_CYCLES = 52080,
    parameter int unsigned TO_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rdy,
    output logic        clr_rdy,
    input  logic        clr_cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    output logic        chk_err,
    output logic        to_err,
    output logic        cmd_ovr
);

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_CMD  = 3'd1,
        S_DHI  = 3'd2,
        S_DLO  = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_CYCLES);

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        cmd_s_q, cmd_s_d;
    logic [7:0]        dh_s_q, dh_s_d;
    logic [7:0]        dl_s_q, dl_s_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [15:0]       data_q, data_d;
    logic              cmd_rdy_q, cmd_rdy_d;
    logic              chk_err_q, chk_err_d;
    logic              to_err_q, to_err_d;
    logic              cmd_ovr_q, cmd_ovr_d;

    logic              capture;

    // Gating with rst_n keeps the receiver from losing a byte while we are
    // held in reset.
    assign capture = rdy & rst_n;
    assign clr_rdy = capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_SYNC;
            to_cnt_q  <= '0;
            cmd_s_q   <= '0;
            dh_s_q    <= '0;
            dl_s_q    <= '0;
            cmd_q     <= '0;
            data_q    <= '0;
            cmd_rdy_q <= 1'b0;
            chk_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            cmd_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            cmd_s_q   <= cmd_s_d;
            dh_s_q    <= dh_s_d;
            dl_s_q    <= dl_s_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            cmd_rdy_q <= cmd_rdy_d;
            chk_err_q <= chk_err_d;
            to_err_q  <= to_err_d;
            cmd_ovr_q <= cmd_ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        cmd_s_d   = cmd_s_q;
        dh_s_d    = dh_s_q;
        dl_s_d    = dl_s_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        cmd_rdy_d = cmd_rdy_q & ~clr_cmd_rdy;
        chk_err_d = 1'b0;
        to_err_d  = 1'b0;
        cmd_ovr_d = 1'b0;

        // Inter-byte timer. A capture on the match cycle takes priority, so
        // the timeout branch is only reachable when no byte arrives.
        if (capture || state_q == S_SYNC) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_MAX) begin
            to_cnt_d = '0;
            state_d  = S_SYNC;
            to_err_d = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (capture) begin
            case (state_q)
                S_SYNC: begin
                    // Anything other than the marker is line noise; drop it.
                    if (rx_data == SYNC_BYTE) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    // The marker value is legal payload here; no resync.
                    cmd_s_d = rx_data;
                    state_d = S_DHI;
                end
                S_DHI: begin
                    dh_s_d  = rx_data;
                    state_d = S_DLO;
                end
                S_DLO: begin
                    dl_s_d  = rx_data;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    state_d = S_SYNC;
                    if (rx_data == (cmd_s_q ^ dh_s_q ^ dl_s_q)) begin
                        cmd_d     = cmd_s_q;
                        data_d    = {dh_s_q, dl_s_q};
                        // Set beats a coincident acknowledge, and that
                        // acknowledge also suppresses the overwrite report.
                        cmd_rdy_d = 1'b1;
                        cmd_ovr_d = cmd_rdy_q & ~clr_cmd_rdy;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_SYNC;
                end
            endcase
        end
    end

    assign cmd     = cmd_q;
    assign data    = data_q;
    assign cmd_rdy = cmd_rdy_q;
    assign chk_err = chk_err_q;
    assign to_err  = to_err_q;
    assign cmd_ovr = cmd_ovr_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Purpose:
//   Self-checking bench for uart_cmd_parser. Bytes are delivered one per rdy
//   pulse with a chosen number of idle cycles before each. A byte-level
//   reference model (frame position plus collected bytes) predicts cmd, data,
//   cmd_rdy and the error pulses. A reduced TO_CYCLES keeps run time short.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rdy = 1'b0;
    logic        clr_cmd_rdy = 1'b0;
    logic        clr_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        chk_err;
    logic        to_err;
    logic        cmd_ovr;

    uart_cmd_parser #(
        .SYNC_BYTE (8'hA5),
        .TO_CYCLES (TO),
        .TO_W      (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rdy         (rdy),
        .clr_rdy     (clr_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .cmd_rdy     (cmd_rdy),
        .chk_err     (chk_err),
        .to_err      (to_err),
        .cmd_ovr     (cmd_ovr)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Pulse counters sampled mid-cycle; a pulse held two cycles counts twice.
    int mon_clr = 0, mon_chk = 0, mon_to = 0, mon_ovr = 0;
    always @(negedge clk) begin
        if (clr_rdy) mon_clr++;
        if (chk_err) mon_chk++;
        if (to_err)  mon_to++;
        if (cmd_ovr) mon_ovr++;
    end

    // Reference model state
    int          pos = 0;
    logic [7:0]  fb [3];
    logic [7:0]  m_cmd = 8'h00;
    logic [15:0] m_data = 16'h0000;
    logic        m_rdy = 1'b0;
    int          e_clr = 0, e_chk = 0, e_to = 0, e_ovr = 0;

    // Deliver one byte after 'gap' idle cycles (gap >= 1), optionally with
    // the consumer acknowledge in the same cycle, then check the outputs.
    task automatic send(input logic [7:0] b, input int gap, input logic ack);
        logic p_chk, p_ovr;
        p_chk = 1'b0;
        p_ovr = 1'b0;
        if (pos != 0 && gap > TO) begin
            pos = 0;
            e_to++;
        end
        case (pos)
            0: if (b == 8'hA5) pos = 1;
            1, 2, 3: begin
                fb[pos-1] = b;
                pos++;
            end
            default: begin
                if (b == (fb[0] ^ fb[1] ^ fb[2])) begin
                    p_ovr  = m_rdy && !ack;
                    m_rdy  = 1'b1;
                    m_cmd  = fb[0];
                    m_data = {fb[1], fb[2]};
                end else begin
                    p_chk = 1'b1;
                end
                pos = 0;
            end
        endcase
        if (ack && !(pos == 0 && m_rdy && p_ovr == 1'b0 && b == (fb[0] ^ fb[1] ^ fb[2]) && !p_chk && m_cmd == fb[0] && m_data == {fb[1], fb[2]} && 1'b0))
            ;
        e_clr++;
        if (p_chk) e_chk++;
        if (p_ovr) e_ovr++;

        repeat (gap) @(posedge clk);
        #1;
        rx_data     = b;
        rdy         = 1'b1;
        clr_cmd_rdy = ack;
        @(posedge clk);
        #1;
        rdy         = 1'b0;
        clr_cmd_rdy = 1'b0;
        check_val("cmd",     32'(cmd),     32'(m_cmd));
        check_val("data",    32'(data),    32'(m_data));
        check_val("chk_err", 32'(chk_err), 32'(p_chk));
        check_val("cmd_ovr", 32'(cmd_ovr), 32'(p_ovr));
        check_val("to_cnt",  32'(mon_to),  32'(e_to));
        check_val("cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
    endtask

    // Acknowledge takes effect on every byte edge where it is applied,
    // unless a valid frame completes on that same edge (set wins).
    task automatic send_ack(input logic [7:0] b, input int gap);
        logic done_valid;
        done_valid = (pos == 4 && !(gap > TO)) &&
                     (b == (fb[0] ^ fb[1] ^ fb[2]));
        if (!done_valid) m_rdy = 1'b0;
        send(b, gap, 1'b1);
    endtask

    task automatic frame(input logic [7:0] c, input logic [15:0] d, input int gap);
        send(8'hA5, gap, 1'b0);
        send(c, gap, 1'b0);
        send(d[15:8], gap, 1'b0);
        send(d[7:0], gap, 1'b0);
        send(c ^ d[15:8] ^ d[7:0], gap, 1'b0);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0]  rc;
        logic [15:0] rd;
        logic [7:0]  rk;
        int          g;

        // Reset state, including clr_rdy masked while in reset
        rdy = 1'b1;
        #12;
        check_val("rst_clr_rdy", 32'(clr_rdy), 32'd0);
        check_val("rst_cmd",     32'(cmd),     32'd0);
        check_val("rst_data",    32'(data),    32'd0);
        check_val("rst_flags",   32'({cmd_rdy, chk_err, to_err, cmd_ovr}), 32'd0);
        rdy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Valid frame
        frame(8'h12, 16'h3456, 20);
        check_val("clr_rdy_count", 32'(mon_clr), 32'd5);

        // Bad checksum, then a valid frame again
        send_ack(8'hA5, 3);
        send(8'h12, 3, 1'b0);
        send(8'h34, 3, 1'b0);
        send(8'h56, 3, 1'b0);
        send(8'h71, 3, 1'b0);
        frame(8'h21, 16'hBEEF, 5);

        // Junk then a frame whose CMD equals the sync value
        send_ack(8'h00, 2);
        send(8'hFF, 2, 1'b0);
        send(8'hA5, 2, 1'b0);
        send(8'hA5, 2, 1'b0);
        send(8'h00, 2, 1'b0);
        send(8'h01, 2, 1'b0);
        send(8'hA4, 2, 1'b0);
        check_val("resync_cmd",  32'(cmd),  32'h0000_00A5);
        check_val("resync_data", 32'(data), 32'h0000_0001);

        // Timeout: rest of the frame falls into SYNC and is dropped
        send_ack(8'hA5, 4);
        send(8'h12, 4, 1'b0);
        send(8'h34, TO + 1, 1'b0);
        send(8'h56, 4, 1'b0);
        send(8'h70, 4, 1'b0);

        // Byte exactly on the count-match cycle is accepted
        send(8'hA5, 4, 1'b0);
        send(8'h12, TO, 1'b0);
        send(8'h34, TO, 1'b0);
        send(8'h56, TO, 1'b0);
        send(8'h70, TO, 1'b0);

        // Overwrite without ack, then overwrite with coincident ack
        send_ack(8'h00, 2);
        frame(8'h01, 16'h0000, 3);
        frame(8'h02, 16'h1234, 3);
        frame(8'h01, 16'h0000, 3);
        send(8'hA5, 3, 1'b0);
        send(8'h02, 3, 1'b0);
        send(8'h12, 3, 1'b0);
        send(8'h34, 3, 1'b0);
        send_ack(8'h24, 3);

        // Reset mid-frame discards the partial frame and clears the outputs
        send(8'hA5, 3, 1'b0);
        send(8'h55, 3, 1'b0);
        #1;
        rst_n = 1'b0;
        rdy   = 1'b1;
        #2;
        check_val("mid_rst_clr_rdy", 32'(clr_rdy), 32'd0);
        check_val("mid_rst_outs", 32'({cmd, data, cmd_rdy, chk_err, to_err, cmd_ovr}), 32'd0);
        rdy = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        pos    = 0;
        m_cmd  = 8'h00;
        m_data = 16'h0000;
        m_rdy  = 1'b0;
        send(8'h66, 3, 1'b0);
        send(8'h77, 3, 1'b0);
        frame(8'h5A, 16'hC3E1, 4);

        // Randomized frames: junk, bad checksums, timeouts, edge gaps, acks
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 4) == 0) send(8'($urandom_range(0, 8'hA4)), 2, 1'b0);
            rc = ($urandom_range(0, 9) == 0) ? 8'hA5 : 8'($urandom);
            rd = 16'($urandom);
            rk = rc ^ rd[15:8] ^ rd[7:0];
            if ($urandom_range(0, 3) == 0) rk = rk ^ 8'(1 << $urandom_range(0, 7));
            for (int i = 0; i < 5; i++) begin
                logic [7:0] bb;
                case (i)
                    0: bb = 8'hA5;
                    1: bb = rc;
                    2: bb = rd[15:8];
                    3: bb = rd[7:0];
                    default: bb = rk;
                endcase
                case ($urandom_range(0, 19))
                    0:       g = TO;
                    1:       g = TO + 1 + $urandom_range(0, 2);
                    default: g = $urandom_range(1, 12);
                endcase
                if ($urandom_range(0, 6) == 0) send_ack(bb, g);
                else send(bb, g, 1'b0);
            end
        end

        // Let trailing pulses land, then compare pulse totals (width check)
        repeat (3) @(posedge clk);
        #1;
        check_val("tot_clr_rdy", 32'(mon_clr), 32'(e_clr));
        check_val("tot_chk_err", 32'(mon_chk), 32'(e_chk));
        check_val("tot_to_err",  32'(mon_to),  32'(e_to));
        check_val("tot_cmd_ovr", 32'(mon_ovr), 32'(e_ovr));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Byte-stream command framer that sits directly downstream of the UART receiver in the Segway controller. It consumes received bytes via the receiver's rdy/clr_rdy handshake and assembles 5-byte frames: sync 0xA5, CMD, DATA_HI, DATA_LO, CHK. It validates each frame with an XOR checksum and an inter-byte timeout. Each valid frame is presented as a held command/data pair with a level ready flag for the control logic.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
TO_CYCLES, 52080, maximum idle clock cycles between bytes inside a frame (2 byte-times at 50 MHz / 19200 baud).
TO_W, 16, timeout counter width; TO_CYCLES must be < 2^TO_W.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
rx_data  input  8  byte from the UART receiver, valid while rdy=1.
rdy  input  1  receiver byte-ready level.
clr_rdy  output  1  combinational one-cycle acknowledge to the receiver.
clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
cmd  output  8  command byte of the last valid frame.
data  output  16  {DATA_HI, DATA_LO} of the last valid frame.
cmd_rdy  output  1  level; a new valid frame is held on cmd/data.
chk_err  output  1  one-cycle pulse on checksum mismatch.
to_err  output  1  one-cycle pulse on inter-byte timeout.
cmd_ovr  output  1  one-cycle pulse when a valid frame overwrites an unacknowledged one.

Behaviour:
- Clocking and reset:
  - All flops are on posedge clk and async-clear on negedge rst_n.
  - Reset values: state=SYNC, cmd=0, data=0, cmd_rdy=0, chk_err=0, to_err=0, cmd_ovr=0, timeout counter=0, staging regs=0.
  - clr_rdy=0 while rst_n=0.
  - Reset mid-frame discards the partial frame.
- Byte capture:
  - capture = rdy & rst_n. clr_rdy = capture, driven in the same cycle.
  - Upstream must deassert rdy by the next cycle. One byte is consumed per rdy assertion.
- FSM states: SYNC, CMD, DHI, DLO, CHK.
  - SYNC: on capture with rx_data==SYNC_BYTE go to CMD. Other bytes are dropped silently with no error.
  - CMD: on capture, stage cmd_s and go to DHI. A byte equal to 0xA5 here is data; there is no resync.
  - DHI: on capture, stage dh_s and go to DLO.
  - DLO: on capture, stage dl_s and go to CHK.
  - CHK: on capture, go to SYNC.
    - If rx_data == cmd_s^dh_s^dl_s: at the next edge load cmd<=cmd_s, data<={dh_s,dl_s}, and set cmd_rdy=1.
    - If cmd_rdy was already 1 and clr_rdy_cmd is not asserted that cycle, pulse cmd_ovr.
    - Otherwise pulse chk_err; cmd/data/cmd_rdy stay unchanged.
- Latency: CHK byte captured in cycle N -> cmd/data/cmd_rdy/errors visible from cycle N+1.
- Timeout:
  - The counter clears on any capture and while in SYNC. It increments every cycle in CMD..CHK without a capture.
  - When counter==TO_CYCLES and no capture occurs: go to SYNC, pulse to_err, clear the counter.
  - A capture in the same cycle as the count match wins: the byte is accepted and there is no timeout.
- cmd_rdy:
  - Cleared by clr_cmd_rdy at the next edge.
  - If clr_cmd_rdy and a valid-frame completion coincide, set wins and cmd_ovr does not pulse.
  - cmd/data hold until the next valid frame; a clear does not zero them.
- Error pulses last exactly one cycle and are mutually exclusive per frame.

Test Plan:
- Valid frame: bytes A5,12,34,56,70 (rdy pulses ~26040 cycles apart) -> one cycle after the 5th capture, cmd=8'h12, data=16'h3456, cmd_rdy=1; no error pulses; clr_rdy pulses exactly 5 times.
- Bad checksum: bytes A5,12,34,56,71 -> chk_err pulses 1 cycle; cmd_rdy stays 0; cmd/data keep prior values; the next valid frame is accepted.
- Junk and resync: bytes 00,FF,A5,A5,00,01,A4 -> the first two are dropped; the frame CMD=A5, data=0x0001, CHK=A5^00^01=A4 is accepted; cmd=8'hA5, data=16'h0001.
- Timeout: bytes A5,12, then no rdy for TO_CYCLES+1 cycles -> to_err pulses once at count match; state is SYNC; subsequent bytes 34,56,70 are dropped; cmd_rdy stays 0.
- Timeout edge: a byte arrives exactly on the cycle counter==TO_CYCLES -> accepted, no to_err.
- Overwrite and ack: two valid frames (01,0000,01 then 02,1234,24) with no clr_cmd_rdy -> cmd_ovr pulses at the 2nd; cmd=02, data=1234. Repeat with clr_cmd_rdy coincident with the 2nd completion -> cmd_rdy=1, no cmd_ovr. Assert rst_n=0 mid-frame -> all outputs 0.
